// File: rtl/cassette_tx.sv
// Apple II cassette WRITE transmitter: header tone, two sync half-cycles,
// MSB-first data bits and a trailing XOR checksum byte, sent as a square
// wave on tape_out. Bytes arrive on a valid/ready stream through a
// one-byte holding register, so the first byte can be prefetched.
module cassette_tx #(
  parameter int HDR_HALF   = 9307,
  parameter int HDR_HALVES = 15400,
  parameter int SYNC_A     = 2864,
  parameter int SYNC_B     = 3580,
  parameter int ZERO_HALF  = 3580,
  parameter int ONE_HALF   = 7159
) (
  input  logic       CLK_14M,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic       tape_out,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_SYNC0,
    S_SYNC1,
    S_DATA,
    S_CSUM,
    S_FIN
  } state_t;

  // Reload value for one half-cycle of a data bit (length N loads N-1).
  function automatic logic [15:0] half_len(input logic b);
    return b ? 16'(ONE_HALF - 1) : 16'(ZERO_HALF - 1);
  endfunction

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] half_cnt_q, half_cnt_d;
  logic        tape_q, tape_d;
  logic [7:0]  cur_byte_q, cur_byte_d;
  logic        cur_last_q, cur_last_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        phase_q, phase_d;
  logic [7:0]  csum_q, csum_d;
  logic        hold_valid_q, hold_valid_d;
  logic [7:0]  hold_data_q, hold_data_d;
  logic        hold_last_q, hold_last_d;
  logic        last_acc_q, last_acc_d;
  logic        stall_q, stall_d;
  logic        underrun_q, underrun_d;

  logic        accept;
  logic        load_req;
  logic        do_load;
  logic [7:0]  load_byte;
  logic        load_last;
  logic [2:0]  bit_idx_m1;
  logic [7:0]  csum_next;

  assign busy       = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done       = (state_q == S_FIN);
  assign in_ready   = busy & ~hold_valid_q & ~last_acc_q;
  assign accept     = in_valid & in_ready;
  assign tape_out   = tape_q;
  assign underrun   = underrun_q;
  assign bit_idx_m1 = bit_idx_q - 3'd1;
  assign csum_next  = csum_q ^ cur_byte_q;

  // Next-state: FSM sequencing, half-cycle timer, holding register and byte loads.
  always_comb begin
    // NOTE: every _d starts from its _q value so no path through this block can infer a latch.
    state_d      = state_q;
    timer_d      = timer_q;
    half_cnt_d   = half_cnt_q;
    tape_d       = tape_q;
    cur_byte_d   = cur_byte_q;
    cur_last_d   = cur_last_q;
    bit_idx_d    = bit_idx_q;
    phase_d      = phase_q;
    csum_d       = csum_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    hold_last_d  = hold_last_q;
    last_acc_d   = last_acc_q;
    stall_d      = stall_q;
    underrun_d   = underrun_q;
    load_req     = 1'b0;
    do_load      = 1'b0;
    load_byte    = 8'h00;
    load_last    = 1'b0;

    if (accept) begin
      hold_valid_d = 1'b1;
      hold_data_d  = in_data;
      hold_last_d  = in_last;
      if (in_last) last_acc_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_HEADER;
          timer_d      = 16'(HDR_HALF - 1);
          half_cnt_d   = 16'd0;
          csum_d       = 8'hFF;
          underrun_d   = 1'b0;
          last_acc_d   = 1'b0;
          hold_valid_d = 1'b0;
          stall_d      = 1'b0;
        end
      end

      S_HEADER: begin
        if (timer_q != 16'd0) begin
          timer_d = timer_q - 16'd1;
        end else begin
          tape_d = ~tape_q;
          if (half_cnt_q == 16'(HDR_HALVES - 1)) begin
            state_d = S_SYNC0;
            timer_d = 16'(SYNC_A - 1);
          end else begin
            half_cnt_d = half_cnt_q + 16'd1;
            timer_d    = 16'(HDR_HALF - 1);
          end
        end
      end

      S_SYNC0: begin
        if (timer_q != 16'd0) begin
          timer_d = timer_q - 16'd1;
        end else begin
          tape_d  = ~tape_q;
          state_d = S_SYNC1;
          timer_d = 16'(SYNC_B - 1);
        end
      end

      S_SYNC1: begin
        if (stall_q) begin
          load_req = 1'b1;
        end else if (timer_q != 16'd0) begin
          timer_d = timer_q - 16'd1;
        end else begin
          tape_d   = ~tape_q;
          load_req = 1'b1;
        end
      end

      S_DATA, S_CSUM: begin
        if (stall_q) begin
          load_req = 1'b1;
        end else if (timer_q != 16'd0) begin
          timer_d = timer_q - 16'd1;
        end else begin
          tape_d = ~tape_q;
          if (!phase_q) begin
            phase_d = 1'b1;
            timer_d = half_len(cur_byte_q[bit_idx_q]);
          end else if (bit_idx_q != 3'd0) begin
            bit_idx_d = bit_idx_m1;
            phase_d   = 1'b0;
            timer_d   = half_len(cur_byte_q[bit_idx_m1]);
          end else if (state_q == S_CSUM) begin
            state_d = S_FIN;
          end else begin
            csum_d = csum_next;
            if (cur_last_q) begin
              state_d    = S_CSUM;
              cur_byte_d = csum_next;
              cur_last_d = 1'b0;
              bit_idx_d  = 3'd7;
              phase_d    = 1'b0;
              timer_d    = half_len(csum_next[7]);
            end else begin
              load_req = 1'b1;
            end
          end
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Byte boundary: take the held byte, or bypass a byte accepted this very
    // cycle, otherwise freeze with tape_out held until one arrives.
    if (load_req) begin
      if (hold_valid_q) begin
        do_load      = 1'b1;
        load_byte    = hold_data_q;
        load_last    = hold_last_q;
        hold_valid_d = 1'b0;
      end else if (accept) begin
        do_load      = 1'b1;
        load_byte    = in_data;
        load_last    = in_last;
        hold_valid_d = 1'b0;
      end else begin
        stall_d    = 1'b1;
        underrun_d = 1'b1;
      end
    end

    if (do_load) begin
      state_d    = S_DATA;
      cur_byte_d = load_byte;
      cur_last_d = load_last;
      bit_idx_d  = 3'd7;
      phase_d    = 1'b0;
      timer_d    = half_len(load_byte[7]);
      stall_d    = 1'b0;
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge CLK_14M) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q      <= S_IDLE;
      timer_q      <= 16'd0;
      half_cnt_q   <= 16'd0;
      tape_q       <= 1'b0;
      cur_last_q   <= 1'b0;
      bit_idx_q    <= 3'd7;
      phase_q      <= 1'b0;
      csum_q       <= 8'hFF;
      hold_valid_q <= 1'b0;
      hold_last_q  <= 1'b0;
      last_acc_q   <= 1'b0;
      stall_q      <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      half_cnt_q   <= half_cnt_d;
      tape_q       <= tape_d;
      cur_last_q   <= cur_last_d;
      bit_idx_q    <= bit_idx_d;
      phase_q      <= phase_d;
      csum_q       <= csum_d;
      hold_valid_q <= hold_valid_d;
      hold_last_q  <= hold_last_d;
      last_acc_q   <= last_acc_d;
      stall_q      <= stall_d;
      underrun_q   <= underrun_d;
    end
  end

  // Byte datapath registers; always qualified by valid/state before use.
  always_ff @(posedge CLK_14M) begin
    // NOTE: data-only registers carry no reset; their qualifiers are reset instead.
    hold_data_q <= hold_data_d;
    cur_byte_q  <= cur_byte_d;
  end

endmodule

// File: tb/tb_cassette_tx.sv
// Self-checking bench for cassette_tx with shortened timing parameters.
// The reference model turns a byte list plus observed acceptance cycles into
// the expected absolute cycle of every tape_out transition.
module tb_cassette_tx;

  localparam int HDR_HALF   = 4;
  localparam int HDR_HALVES = 4;
  localparam int SYNC_A     = 2;
  localparam int SYNC_B     = 3;
  localparam int ZERO_HALF  = 2;
  localparam int ONE_HALF   = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready, tape_out, busy, done, underrun;

  cassette_tx #(
    .HDR_HALF(HDR_HALF), .HDR_HALVES(HDR_HALVES), .SYNC_A(SYNC_A),
    .SYNC_B(SYNC_B), .ZERO_HALF(ZERO_HALF), .ONE_HALF(ONE_HALF)
  ) dut (
    .CLK_14M(clk), .reset(reset), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .tape_out(tape_out), .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Cycle counter: value N at a negedge means N rising edges have occurred.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: logs the cycle of every tape_out transition and every done pulse.
  int   edges[$];
  logic prev_tape = 1'b0;
  int   done_total = 0;
  int   last_done_cyc = -1;
  always @(negedge clk) begin
    if (tape_out !== prev_tape) edges.push_back(cyc);
    prev_tape <= tape_out;
    if (done === 1'b1) begin
      done_total    <= done_total + 1;
      last_done_cyc <= cyc;
    end
  end

  logic [7:0] tx_bytes[$];
  int         tx_delay[$];
  int         acc[$];
  bit         feed_timeout;
  bit         extra_byte;
  bit         extra_taken;

  task automatic do_start(output int sc);
    @(negedge clk);
    start = 1'b1;
    sc = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_after_start: got %b want 1", busy);
    end
  endtask

  // Presents each byte after its delay and records the accepting edge.
  task automatic feeder();
    acc.delete();
    for (int k = 0; k < tx_bytes.size(); k++) begin
      int tries;
      repeat (tx_delay[k]) @(negedge clk);
      in_valid = 1'b1;
      in_data  = tx_bytes[k];
      in_last  = (k == tx_bytes.size() - 1);
      tries = 0;
      while (in_ready !== 1'b1 && tries < 2000) begin
        @(negedge clk);
        tries++;
      end
      if (in_ready !== 1'b1) feed_timeout = 1'b1;
      acc.push_back(cyc + 1);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
    if (extra_byte) begin
      in_valid = 1'b1;
      in_data  = 8'h3C;
      for (int i = 0; i < 120; i++) begin
        if (in_ready === 1'b1) extra_taken = 1'b1;
        @(negedge clk);
      end
      in_valid = 1'b0;
    end
  endtask

  // Reference timeline: each half-cycle of length N ends N cycles after it
  // begins; a data byte cannot begin before the cycle it was accepted on.
  task automatic emit_byte(input logic [7:0] b, inout int t, inout int q[$]);
    for (int i = 7; i >= 0; i--) begin
      int d;
      d = b[i] ? ONE_HALF : ZERO_HALF;
      t += d; q.push_back(t);
      t += d; q.push_back(t);
    end
  endtask

  task automatic run_transfer(input string name, input int extra_start_at);
    int sc, base, dbase, t, nobs, bad_idx;
    int exp_q[$];
    bit exp_ur;
    logic [7:0] csum;
    base = edges.size();
    dbase = done_total;
    feed_timeout = 1'b0;
    extra_taken = 1'b0;
    do_start(sc);
    fork
      feeder();
      begin
        if (extra_start_at > 0) begin
          repeat (extra_start_at) @(negedge clk);
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      end
      begin
        int w;
        w = 0;
        while (done_total == dbase && w < 20000) begin
          @(negedge clk);
          w++;
        end
      end
    join
    repeat (10) @(negedge clk);

    t = sc;
    exp_ur = 1'b0;
    repeat (HDR_HALVES) begin t += HDR_HALF; exp_q.push_back(t); end
    t += SYNC_A; exp_q.push_back(t);
    t += SYNC_B; exp_q.push_back(t);
    csum = 8'hFF;
    for (int k = 0; k < tx_bytes.size(); k++) begin
      if (k < acc.size() && acc[k] > t) begin
        exp_ur = 1'b1;
        t = acc[k];
      end
      emit_byte(tx_bytes[k], t, exp_q);
      csum = csum ^ tx_bytes[k];
    end
    emit_byte(csum, t, exp_q);

    tests_run++;
    if (feed_timeout) begin
      tests_failed++;
      $display("FAIL %s feed_timeout: got 1 want 0", name);
    end
    nobs = edges.size() - base;
    tests_run++;
    if (nobs != exp_q.size()) begin
      tests_failed++;
      $display("FAIL %s edge_count: got %0d want %0d", name, nobs, exp_q.size());
    end
    bad_idx = -1;
    for (int i = 0; i < exp_q.size() && i < nobs; i++)
      if (bad_idx < 0 && edges[base + i] != exp_q[i]) bad_idx = i;
    tests_run++;
    if (bad_idx >= 0) begin
      tests_failed++;
      $display("FAIL %s edge_time[%0d]: got cycle %0d want %0d", name, bad_idx,
               edges[base + bad_idx] - sc, exp_q[bad_idx] - sc);
    end
    tests_run++;
    if (done_total - dbase != 1) begin
      tests_failed++;
      $display("FAIL %s done_pulses: got %0d want 1", name, done_total - dbase);
    end
    tests_run++;
    if (last_done_cyc != t) begin
      tests_failed++;
      $display("FAIL %s done_cycle: got %0d want %0d", name, last_done_cyc - sc, t - sc);
    end
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s idle_after: got busy=%b done=%b want 0 0", name, busy, done);
    end
    tests_run++;
    if (underrun !== exp_ur) begin
      tests_failed++;
      $display("FAIL %s underrun: got %b want %b", name, underrun, exp_ur);
    end
    if (extra_byte) begin
      tests_run++;
      if (extra_taken) begin
        tests_failed++;
        $display("FAIL %s extra_byte_accepted: got 1 want 0", name);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests_run++;
    if ({tape_out, busy, done, in_ready, underrun} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_values: got %b want 00000",
               {tape_out, busy, done, in_ready, underrun});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_byte();
    tx_bytes = '{8'hA5}; tx_delay = '{0}; extra_byte = 1'b0;
    run_transfer("single_a5", 0);
  endtask

  task automatic test_two_bytes();
    tx_bytes = '{8'h00, 8'hFF}; tx_delay = '{0, 0}; extra_byte = 1'b0;
    run_transfer("two_bytes", 0);
  endtask

  task automatic test_underrun();
    tx_bytes = '{8'h00, 8'hFF}; tx_delay = '{0, 71}; extra_byte = 1'b0;
    run_transfer("underrun", 0);
  endtask

  // Second byte accepted on exactly the edge where the first byte ends.
  task automatic test_simultaneous_load();
    tx_bytes = '{8'h00, 8'hFF}; tx_delay = '{0, 51}; extra_byte = 1'b0;
    run_transfer("simul_load", 0);
  endtask

  task automatic test_reset_mid_op();
    int sc;
    // Stall with underrun set, then reset.
    do_start(sc);
    in_valid = 1'b1; in_data = 8'h81; in_last = 1'b0;
    while (in_ready !== 1'b1 && cyc < sc + 50) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    while (cyc < sc + 75) @(negedge clk);
    tests_run++;
    if (underrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_underrun: got %b want 1", underrun);
    end
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({tape_out, busy, done, in_ready, underrun} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_in_stall: got %b want 00000",
               {tape_out, busy, done, in_ready, underrun});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    // Reset in the middle of a bit while tape_out is high.
    do_start(sc);
    in_valid = 1'b1; in_data = 8'h81; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    while (cyc < sc + 27) @(negedge clk);
    tests_run++;
    if (tape_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL tape_before_reset: got %b want 1", tape_out);
    end
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({tape_out, busy, done, in_ready, underrun} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_in_data: got %b want 00000",
               {tape_out, busy, done, in_ready, underrun});
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tx_bytes = '{8'h3E}; tx_delay = '{2}; extra_byte = 1'b0;
    run_transfer("after_reset", 0);
  endtask

  task automatic test_start_ignored();
    int base;
    tx_bytes = '{8'hC3, 8'h17}; tx_delay = '{1, 0}; extra_byte = 1'b0;
    run_transfer("start_in_header", 6);
    base = edges.size();
    @(negedge clk);
    start = 1'b1; reset = 1'b1;
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    repeat (8) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || edges.size() != base) begin
      tests_failed++;
      $display("FAIL start_with_reset: got busy=%b edges=%0d want 0 0",
               busy, edges.size() - base);
    end
  endtask

  task automatic test_last_then_extra();
    tx_bytes = '{8'h69}; tx_delay = '{0}; extra_byte = 1'b1;
    run_transfer("last_then_extra", 0);
    extra_byte = 1'b0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int n;
      tx_bytes.delete();
      tx_delay.delete();
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        tx_bytes.push_back(8'($urandom_range(0, 255)));
        tx_delay.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(30, 90)
                                                        : $urandom_range(0, 6));
      end
      extra_byte = 1'b0;
      run_transfer($sformatf("random%0d", it), 0);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_two_bytes();
    test_underrun();
    test_simultaneous_load();
    test_reset_mid_op();
    test_start_ignored();
    test_last_then_extra();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
